mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences a single shared, single-ported backing memory between two requesters: instruction fetch (IF) and data access (DM).
- Lets the pipelined CPU run from one unified memory with a variable-latency ready handshake.
- Sits between the IF/MEM pipeline stages and the memory. It drives stall signals that the hazard logic uses to freeze PC, IF_ID and the later pipeline registers until the owning access completes.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MAX_DM_STREAK, 4, maximum consecutive DM grants while IF is waiting; the next grant is then forced to IF.
- TIMEOUT, 255, maximum cycles to wait for mem_ready_i before aborting. Counter width is clog2(TIMEOUT+1).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- if_req_i  in  1  IF read request (level).
- if_addr_i  in  ADDR_W  IF read address.
- if_rdata_o  out  DATA_W  IF read data; valid while if_ack_o is high.
- if_ack_o  out  1  one-cycle IF completion pulse.
- if_stall_o  out  1  equals if_req_i & ~if_ack_o (combinational).
- dm_req_i  in  1  DM request (level).
- dm_we_i  in  1  DM write enable; 1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  DM address.
- dm_wdata_i  in  DATA_W  DM write data.
- dm_rdata_o  out  DATA_W  DM read data; valid while dm_ack_o is high.
- dm_ack_o  out  1  one-cycle DM completion pulse.
- dm_stall_o  out  1  equals dm_req_i & ~dm_ack_o (combinational).
- mem_req_o  out  1  backing-memory request.
- mem_we_o  out  1  backing-memory write enable.
- mem_addr_o  out  ADDR_W  backing-memory address.
- mem_wdata_o  out  DATA_W  backing-memory write data.
- mem_rdata_i  in  DATA_W  backing-memory read data; sampled when mem_ready_i is high.
- mem_ready_i  in  1  backing-memory completion; any latency of 1 or more cycles.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including the rdata registers, streak counter, timeout counter and err_o.
  - Any transaction in flight is dropped; no ack is issued.
- States:
  - IDLE: grant decision.
    - If dm_req_i is high and (if_req_i is low or streak < MAX_DM_STREAK): go to BUSY_DM.
    - Else if if_req_i is high: go to BUSY_IF.
    - Else: stay in IDLE.
    - On the grant edge, latch addr, we and wdata into the mem_* output registers. For IF, we = 0.
  - BUSY_IF / BUSY_DM:
    - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o are held stable.
    - On a cycle with mem_ready_i high: capture mem_rdata_i into the owner's rdata register, drop mem_req_o at the next edge, go to RESP.
  - RESP: the owner's ack is high for exactly this cycle; then go to IDLE.
  - Earliest re-grant is the cycle after RESP.
- Latency: request seen in IDLE at cycle t, mem_ready_i at cycle t+1+L → ack at cycle t+2+L. With L = 0 (ready in the first BUSY cycle) the ack is at t+2.
- Write ack: a DM write also returns an ack. dm_rdata_o then carries the mem_rdata_i value captured on the ready cycle; the value is don't-care.
- Streak counter:
  - Increments on each DM grant made while if_req_i is high.
  - Clears on any IF grant and on any grant made while if_req_i is low.
  - Saturates at MAX_DM_STREAK.
- Timeout counter:
  - Clears on entry to BUSY_* and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT: set err_o (sticky until reset), go to RESP, and ack the owner with rdata = 0.
- Boundary conditions:
  - A request dropped mid-transaction still completes; the ack pulses and the requester ignores it.
  - Address or data changes during BUSY are ignored, because the latched values are used.
  - mem_ready_i while in IDLE or RESP is ignored.
  - Both requests high in IDLE: DM wins unless the streak limit has been reached.
  - Never more than one outstanding memory request. if_ack_o and dm_ack_o are never high together.

Test Plan:
- Single IF read: if_req_i = 1, addr 0x10, memory returns 0xDEADBEEF with ready 2 cycles after mem_req_o rises → mem_addr_o = 0x10, mem_we_o = 0; if_ack_o pulses once with if_rdata_o = 0xDEADBEEF; if_stall_o is high until the ack cycle.
- DM write: dm_req_i = 1, we = 1, addr 0x20, wdata 0x5 → mem_we_o = 1 and mem_wdata_o = 0x5 held stable until ready; dm_ack_o pulses once; err_o = 0.
- Simultaneous requests: both asserted in IDLE → DM is served first, then IF is granted the cycle after the DM RESP; the acks are in separate cycles.
- Starvation: if_req_i held high while dm_req_i is reasserted continuously, ready at L = 0 → exactly 4 DM grants, then an IF grant, then DM resumes.
- Timeout: if_req_i = 1 with mem_ready_i held low → after 255 BUSY cycles, if_ack_o pulses with if_rdata_o = 0 and err_o stays 1 until rst_i.
- Reset mid-transaction: rst_i pulsed during BUSY_DM → next cycle mem_req_o = 0, state IDLE, no dm_ack_o; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported backing memory between instruction
// fetch (IF) and data access (DM) requesters.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   if_req_i, if_addr_i       IF read request (level) and address
//   if_rdata_o, if_ack_o      IF read data, one-cycle completion pulse
//   if_stall_o                if_req_i & ~if_ack_o
//   dm_req_i, dm_we_i,
//   dm_addr_i, dm_wdata_i     DM request (level), write enable, address, data
//   dm_rdata_o, dm_ack_o      DM read data, one-cycle completion pulse
//   dm_stall_o                dm_req_i & ~dm_ack_o
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o   backing-memory request, held stable while busy
//   mem_rdata_i, mem_ready_i  backing-memory read data and completion
//   err_o                     sticky timeout flag
//
// One transaction is in flight at a time: IDLE -> BUSY_IF/BUSY_DM -> RESP.
// DM normally wins a tie, but after MAX_DM_STREAK back-to-back DM grants with
// IF waiting, the next grant is forced to IF.
module mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              err_o
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_dm_q;     // owner of the transaction now in BUSY/RESP
  logic [SW-1:0] streak_q;
  logic [TW-1:0] tmo_q;

  logic grant_dm, grant_if, busy, done_ok, done_tmo;

  assign busy = (state_q == BUSY_IF) || (state_q == BUSY_DM);

  // Next-state / grant decision
  always_comb begin
    state_d  = state_q;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    done_ok  = 1'b0;
    done_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req_i && (!if_req_i || streak_q < SW'(MAX_DM_STREAK))) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
        end else if (if_req_i) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        // Ready on the final allowed cycle still counts as a normal completion.
        if (mem_ready_i) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          done_tmo = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      streak_q    <= '0;
      tmo_q       <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
    end else begin
      state_q <= state_d;

      if (grant_dm) begin
        owner_dm_q  <= 1'b1;
        mem_req_o   <= 1'b1;
        mem_we_o    <= dm_we_i;
        mem_addr_o  <= dm_addr_i;
        mem_wdata_o <= dm_wdata_i;
        tmo_q       <= '0;
        // Only DM grants that bypass a waiting IF count toward the streak.
        if (!if_req_i)
          streak_q <= '0;
        else if (streak_q < SW'(MAX_DM_STREAK))
          streak_q <= streak_q + 1'b1;
      end else if (grant_if) begin
        owner_dm_q  <= 1'b0;
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        streak_q    <= '0;
        tmo_q       <= '0;
      end

      if (busy && !mem_ready_i && !done_tmo)
        tmo_q <= tmo_q + 1'b1;

      if (done_ok || done_tmo) begin
        mem_req_o <= 1'b0;
        // A timed-out access returns zero data to its owner.
        if (owner_dm_q) dm_rdata_o <= done_ok ? mem_rdata_i : '0;
        else            if_rdata_o <= done_ok ? mem_rdata_i : '0;
      end

      if (done_tmo)
        err_o <= 1'b1;
    end
  end

  assign if_ack_o   = (state_q == RESP) && !owner_dm_q;
  assign dm_ack_o   = (state_q == RESP) &&  owner_dm_q;
  assign if_stall_o = if_req_i & ~if_ack_o;
  assign dm_stall_o = dm_req_i & ~dm_ack_o;

endmodule
